serial_adder: RTL

Bit-serial ripple adder that consumes the half-adder output pair (sum, carry). It chains two `half_adder` cells and a carry flip-flop into a full-add slice, then iterates over an N-bit operand pair one bit per clock. It accepts operands on a valid/ready input handshake and returns the N-bit sum plus carry-out on a valid/ready output handshake. This is the first sequential arithmetic stage in the design and the reuse point for the existing half-adder cell.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_full_adder_slice.sv | 31 +++
 rtl/serial_adder_half_adder.sv | 12 +
 rtl/serial_adder.sv | 97 +++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the
// default operand width.
package serial_adder_pkg;

  localparam int unsigned SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    SA_IDLE  = 2'd0,
    SA_SHIFT = 2'd1,
    SA_DONE  = 2'd2
  } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_slice.sv
// One-bit full-add slice built from two half-adder cells and an OR of their
// carries; the two carries can never both be set, so OR equals XOR here.
module full_adder_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic h1_sum;
  logic h1_carry;
  logic h2_carry;

  half_adder u_h1 (
    .a_i     (a_i),
    .b_i     (b_i),
    .sum_o   (h1_sum),
    .carry_o (h1_carry)
  );

  half_adder u_h2 (
    .a_i     (h1_sum),
    .b_i     (cin_i),
    .sum_o   (sum_o),
    .carry_o (h2_carry)
  );

  assign cout_o = h1_carry | h2_carry;

endmodule : full_adder_slice

// File: rtl/serial_adder_half_adder.sv
// Half-adder cell: one-bit sum and carry of two inputs.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule : half_adder

// File: rtl/serial_adder.sv
// Bit-serial ripple adder. Operands are captured on the input handshake,
// added LSB first through one full-add slice (one bit per clock), and the
// WIDTH-bit sum plus carry-out are held on the output handshake until taken.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sa_state_e        state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic slice_sum;
  logic slice_carry;

  full_adder_slice u_slice (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_carry)
  );

  // Control FSM plus datapath: capture on accept, shift one bit per clock,
  // hold the result in DONE until the consumer takes it.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking '=' would let later lines see the
  // already-shifted operands within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SA_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        SA_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= SA_SHIFT;
          end
        end
        SA_SHIFT: begin
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          sum_q   <= {slice_sum, sum_q[WIDTH-1:1]};
          carry_q <= slice_carry;
          if (cnt_q == LAST_CNT) begin
            // Counter is held at its last value so it never wraps.
            state_q <= SA_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SA_DONE: begin
          if (out_ready) begin
            state_q <= SA_IDLE;
          end
        end
        default: state_q <= SA_IDLE;
      endcase
    end
  end

  // Handshake and status outputs are pure decodes of the registered state.
  assign in_ready  = (state_q == SA_IDLE);
  assign out_valid = (state_q == SA_DONE);
  assign busy      = (state_q == SA_SHIFT) || (state_q == SA_DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule : serial_adder
